// File: rtl/seven_seg_capture_if.sv
// Display-bus bundle between a seven-segment display source and the capture block.
// The master drives the (active-low) pins; the slave returns the recovered digits.
interface seven_seg_capture_if;
    logic [6:0]  seg_in;
    logic        dp_in;
    logic [7:0]  anode_in;
    logic [31:0] digits;
    logic [7:0]  digit_valid;
    logic [7:0]  digit_err;
    logic [7:0]  dp_out;
    logic        upd_pulse;
    logic [2:0]  upd_idx;
    logic        frame_done;
    logic        stale;

    modport master (
        output seg_in, dp_in, anode_in,
        input  digits, digit_valid, digit_err, dp_out,
        input  upd_pulse, upd_idx, frame_done, stale
    );

    modport slave (
        input  seg_in, dp_in, anode_in,
        output digits, digit_valid, digit_err, dp_out,
        output upd_pulse, upd_idx, frame_done, stale
    );
endinterface

// File: rtl/seven_seg_capture.sv
// Recovers hex digits and decimal points from a multiplexed, active-low 8-digit
// seven-segment bus, with glitch filtering, frame tracking and a stale watchdog.
//
// state | meaning
// WAIT  | counting identical samples; commits once the window fills on a one-hot-low anode
// HOLD  | current steady sample already committed; waiting for the bus to change
module seven_seg_capture #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input logic               clk,
    input logic               rst_n,
    seven_seg_capture_if.slave disp
);
    localparam int               WD_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]       STAB_MAX = 8'(STABLE_CYCLES);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0]  WD_TOP   = WD_W'(TIMEOUT_CYCLES);
    localparam logic [15:0]      IDLE     = 16'hFFFF;

    typedef enum logic {ST_WAIT = 1'b0, ST_HOLD = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [15:0]     samp_q, prev_q;
    logic [7:0]      stab_q, stab_d;
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic [31:0]     digits_q, digits_d;
    logic [7:0]      valid_q, valid_d;
    logic [7:0]      err_q, err_d;
    logic [7:0]      dp_q, dp_d;
    logic [7:0]      seen_q, seen_d;
    logic            upd_q, upd_d;
    logic [2:0]      idx_q, idx_d;
    logic            frame_q, frame_d;
    logic            stale_q, stale_d;

    logic            commit;
    logic            changed;
    logic            one_hot;
    logic            timeout;
    logic [7:0]      anode;
    logic [2:0]      hit_idx;
    logic [4:0]      dec;
    logic [7:0]      seen_upd;

    // Returns {legal, nibble}; anything outside the 16 glyphs (blank included) is illegal.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        case (seg)
            7'h40:   seg_decode = 5'h10;
            7'h79:   seg_decode = 5'h11;
            7'h24:   seg_decode = 5'h12;
            7'h30:   seg_decode = 5'h13;
            7'h19:   seg_decode = 5'h14;
            7'h12:   seg_decode = 5'h15;
            7'h02:   seg_decode = 5'h16;
            7'h78:   seg_decode = 5'h17;
            7'h00:   seg_decode = 5'h18;
            7'h10:   seg_decode = 5'h19;
            7'h08:   seg_decode = 5'h1A;
            7'h03:   seg_decode = 5'h1B;
            7'h46:   seg_decode = 5'h1C;
            7'h21:   seg_decode = 5'h1D;
            7'h06:   seg_decode = 5'h1E;
            7'h0E:   seg_decode = 5'h1F;
            default: seg_decode = 5'h00;
        endcase
    endfunction

    assign anode   = samp_q[15:8];
    assign changed = (samp_q != prev_q);
    assign one_hot = $onehot(~anode);
    assign dec     = seg_decode(samp_q[6:0]);

    always_comb begin
        hit_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!anode[i]) hit_idx = 3'(i);
        end
    end

    // Stability counter: restarts at 1 on any change, saturates at the window length.
    always_comb begin
        stab_d = stab_q;
        if (changed) begin
            stab_d = 8'd1;
        end else if (state_q == ST_WAIT && stab_q < STAB_MAX) begin
            stab_d = stab_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT: if (stab_d == STAB_MAX && one_hot) state_d = ST_HOLD;
            ST_HOLD: if (changed) state_d = ST_WAIT;
            default: state_d = ST_WAIT;
        endcase
    end

    always_comb begin
        commit = (state_q == ST_WAIT) && (stab_d == STAB_MAX) && one_hot;
    end

    always_comb begin
        digits_d = digits_q;
        valid_d  = valid_q;
        err_d    = err_q;
        dp_d     = dp_q;
        seen_d   = seen_q;
        stale_d  = stale_q;
        idx_d    = idx_q;
        upd_d    = commit;
        frame_d  = 1'b0;
        seen_upd = seen_q | (8'd1 << hit_idx);
        timeout  = !commit && (wdog_q == WD_LAST);

        if (commit) begin
            wdog_d = '0;
        end else if (wdog_q == WD_TOP) begin
            wdog_d = WD_TOP;
        end else begin
            wdog_d = wdog_q + 1'b1;
        end

        if (timeout) begin
            stale_d = 1'b1;
            valid_d = 8'h00;
            seen_d  = 8'h00;
        end

        if (commit) begin
            stale_d      = 1'b0;
            idx_d        = hit_idx;
            dp_d[hit_idx] = ~samp_q[7];
            if (dec[4]) begin
                digits_d[{hit_idx, 2'b00} +: 4] = dec[3:0];
                valid_d[hit_idx] = 1'b1;
                err_d[hit_idx]   = 1'b0;
            end else begin
                valid_d[hit_idx] = 1'b0;
                err_d[hit_idx]   = 1'b1;
            end
            if (seen_upd == 8'hFF) begin
                frame_d = 1'b1;
                seen_d  = 8'h00;
            end else begin
                seen_d  = seen_upd;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_q   <= IDLE;
            prev_q   <= IDLE;
            stab_q   <= '0;
            wdog_q   <= '0;
            digits_q <= '0;
            valid_q  <= '0;
            err_q    <= '0;
            dp_q     <= '0;
            seen_q   <= '0;
            upd_q    <= 1'b0;
            idx_q    <= '0;
            frame_q  <= 1'b0;
            stale_q  <= 1'b0;
        end else begin
            samp_q   <= {disp.anode_in, disp.dp_in, disp.seg_in};
            prev_q   <= samp_q;
            stab_q   <= stab_d;
            wdog_q   <= wdog_d;
            digits_q <= digits_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            dp_q     <= dp_d;
            seen_q   <= seen_d;
            upd_q    <= upd_d;
            idx_q    <= idx_d;
            frame_q  <= frame_d;
            stale_q  <= stale_d;
        end
    end

    assign disp.digits      = digits_q;
    assign disp.digit_valid = valid_q;
    assign disp.digit_err   = err_q;
    assign disp.dp_out      = dp_q;
    assign disp.upd_pulse   = upd_q;
    assign disp.upd_idx     = idx_q;
    assign disp.frame_done  = frame_q;
    assign disp.stale       = stale_q;
endmodule

// File: tb/tb_seven_seg_capture.sv
// Bench for seven_seg_capture: a segment-level reference model predicts every commit
// and a monitor compares the full output image each cycle.
module tb_seven_seg_capture;
    localparam int S = 4;
    localparam int T = 16;
    localparam logic [6:0] PAT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct {
        int unsigned edge_n;
        logic [2:0]  idx;
        logic [31:0] digits;
        logic [7:0]  valid;
        logic [7:0]  err;
        logic [7:0]  dp;
        logic        frame;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    seven_seg_capture_if disp();

    seven_seg_capture #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .disp (disp)
    );

    always #5 clk = ~clk;

    int unsigned cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    int    checks = 0;
    int    failures = 0;
    int    frame_cnt = 0;
    logic  mon_en = 1'b0;
    exp_t  q[$];

    // Reference model state (what the outputs should hold after the latest predicted commit)
    logic [31:0] m_digits;
    logic [7:0]  m_valid, m_err, m_dp, m_seen;
    int unsigned m_last;
    logic [15:0] prev_val;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    function automatic logic [4:0] ref_decode(input logic [6:0] seg);
        for (int j = 0; j < 16; j++) begin
            if (PAT[j] == seg) return {1'b1, 4'(j)};
        end
        return 5'd0;
    endfunction

    task automatic model_reset();
        m_digits = '0; m_valid = '0; m_err = '0; m_dp = '0; m_seen = '0;
        m_last   = 0;
        prev_val = 16'hFFFF;
        q.delete();
    endtask

    // A segment held for at least S sampling edges on a one-hot-low anode commits
    // exactly once, S edges after its first sampling edge.
    task automatic apply(input logic [7:0] an, input logic dp, input logic [6:0] seg, input int len);
        exp_t        it;
        int unsigned start, c;
        logic [4:0]  dec;
        int          idx;
        if ({an, dp, seg} == prev_val) seg[0] = ~seg[0];
        start = cyc + 1;
        if (len >= S && $onehot(~an)) begin
            idx = 0;
            for (int i = 0; i < 8; i++) if (!an[i]) idx = i;
            c = start + S;
            if (c - m_last > T) begin
                m_valid = '0;
                m_seen  = '0;
            end
            dec = ref_decode(seg);
            if (dec[4]) begin
                m_digits[idx*4 +: 4] = dec[3:0];
                m_valid[idx] = 1'b1;
                m_err[idx]   = 1'b0;
            end else begin
                m_valid[idx] = 1'b0;
                m_err[idx]   = 1'b1;
            end
            m_dp[idx]   = ~dp;
            m_seen[idx] = 1'b1;
            it.frame    = (m_seen == 8'hFF);
            if (it.frame) m_seen = '0;
            m_last    = c;
            it.edge_n = c;
            it.idx    = 3'(idx);
            it.digits = m_digits;
            it.valid  = m_valid;
            it.err    = m_err;
            it.dp     = m_dp;
            q.push_back(it);
        end
        prev_val      = {an, dp, seg};
        disp.anode_in = an;
        disp.dp_in    = dp;
        disp.seg_in   = seg;
        repeat (len) @(posedge clk);
        #1;
    endtask

    // Monitor: expected output image, advanced by popped commits and the watchdog rule
    logic [31:0] c_digits;
    logic [7:0]  c_valid, c_err, c_dp;
    logic        c_stale;
    int unsigned mlast;
    initial begin
        exp_t it;
        logic exp_now;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                c_digits = '0; c_valid = '0; c_err = '0; c_dp = '0; c_stale = 1'b0;
                mlast = 0;
            end else begin
                exp_now = (q.size() > 0) && (q[0].edge_n == cyc);
                chk("upd_pulse", {31'd0, disp.upd_pulse}, {31'd0, exp_now});
                if (disp.frame_done) frame_cnt++;
                if (exp_now) begin
                    it       = q.pop_front();
                    c_digits = it.digits;
                    c_valid  = it.valid;
                    c_err    = it.err;
                    c_dp     = it.dp;
                    c_stale  = 1'b0;
                    mlast    = cyc;
                    chk("upd_idx", {29'd0, disp.upd_idx}, {29'd0, it.idx});
                    chk("frame_done", {31'd0, disp.frame_done}, {31'd0, it.frame});
                end else begin
                    if (cyc - mlast == T) begin
                        c_stale = 1'b1;
                        c_valid = '0;
                    end
                    chk("frame_done_idle", {31'd0, disp.frame_done}, 32'd0);
                end
                chk("digits", disp.digits, c_digits);
                chk("digit_valid", {24'd0, disp.digit_valid}, {24'd0, c_valid});
                chk("digit_err", {24'd0, disp.digit_err}, {24'd0, c_err});
                chk("dp_out", {24'd0, disp.dp_out}, {24'd0, c_dp});
                chk("stale", {31'd0, disp.stale}, {31'd0, c_stale});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit cyc=%0d", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        logic [7:0] an;
        logic [6:0] seg;
        int         f0;
        disp.anode_in = 8'hFF;
        disp.dp_in    = 1'b1;
        disp.seg_in   = 7'h7F;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;

        // Digit 0 showing '0', held well past the window
        apply(8'hFE, 1'b1, 7'h40, 10);
        chk("t1_nibble0", {28'd0, disp.digits[3:0]}, 32'd0);
        chk("t1_valid", {24'd0, disp.digit_valid}, 32'h01);
        chk("t1_dp0", {31'd0, disp.dp_out[0]}, 32'd0);

        // Scan 1..8 across digits 0..7, dp lit on digit 3
        f0 = frame_cnt;
        for (int d = 0; d < 8; d++) begin
            apply(~8'(1 << d), (d == 3) ? 1'b0 : 1'b1, PAT[d+1], 6);
        end
        chk("scan_digits", disp.digits, 32'h87654321);
        chk("scan_valid", {24'd0, disp.digit_valid}, 32'hFF);
        chk("scan_dp", {24'd0, disp.dp_out}, 32'h08);
        chk("scan_frames", frame_cnt - f0, 32'd1);

        // Glitching digit 2, then a steady '2'
        for (int k = 0; k < 20; k++) apply(8'hFB, 1'b1, (k % 2 == 0) ? 7'h24 : 7'h79, 1);
        apply(8'hFB, 1'b1, 7'h24, 8);
        chk("toggle_nibble2", {28'd0, disp.digits[11:8]}, 32'd2);

        // Blank and garbage on digit 5
        apply(8'hDF, 1'b1, 7'h7F, 8);
        chk("blank_err5", {31'd0, disp.digit_err[5]}, 32'd1);
        apply(8'hDF, 1'b1, 7'h55, 8);
        chk("bad_err5", {31'd0, disp.digit_err[5]}, 32'd1);
        chk("bad_valid5", {31'd0, disp.digit_valid[5]}, 32'd0);
        chk("bad_nibble5", {28'd0, disp.digits[23:20]}, 32'd6);

        // Window boundary: one sample short, then exactly the window
        apply(8'hBF, 1'b1, 7'h19, S - 1);
        apply(8'hBF, 1'b1, 7'h12, S);

        // Illegal anodes never commit
        apply(8'hFC, 1'b1, 7'h40, 50);
        apply(8'hFF, 1'b1, 7'h40, 50);

        // Watchdog
        apply(8'hFD, 1'b1, 7'h79, 6);
        apply(8'hFF, 1'b1, 7'h79, 30);
        chk("wd_stale", {31'd0, disp.stale}, 32'd1);
        chk("wd_valid", {24'd0, disp.digit_valid}, 32'h00);
        apply(8'hEF, 1'b1, 7'h19, 6);
        chk("wd_recover_stale", {31'd0, disp.stale}, 32'd0);
        chk("wd_recover_valid", {24'd0, disp.digit_valid}, 32'h10);

        // Randomised segments
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(9) < 8) an = ~8'(1 << $urandom_range(7));
            else                       an = 8'($urandom());
            if ($urandom_range(3) == 0) seg = 7'($urandom());
            else                        seg = PAT[$urandom_range(15)];
            apply(an, 1'($urandom()), seg, int'($urandom_range(8, 1)));
        end
        apply(8'hFF, 1'b1, 7'h7F, S + 4);
        chk("queue_drained_pre_reset", q.size(), 32'd0);

        // Reset in the middle of a stability window
        mon_en = 1'b0;
        disp.anode_in = 8'hF7;
        disp.dp_in    = 1'b1;
        disp.seg_in   = 7'h30;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_digits", disp.digits, 32'd0);
        chk("rst_valid", {24'd0, disp.digit_valid}, 32'd0);
        chk("rst_err", {24'd0, disp.digit_err}, 32'd0);
        chk("rst_dp", {24'd0, disp.dp_out}, 32'd0);
        chk("rst_ctrl", {28'd0, disp.upd_pulse, disp.frame_done, disp.stale, 1'b0}, 32'd0);
        chk("rst_idx", {29'd0, disp.upd_idx}, 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;
        apply(8'hF7, 1'b1, 7'h30, 6);
        for (int k = 0; k < 10; k++) begin
            apply(~8'(1 << $urandom_range(7)), 1'($urandom()), PAT[$urandom_range(15)],
                  int'($urandom_range(7, 2)));
        end
        apply(8'hFF, 1'b1, 7'h7F, S + 4);
        chk("queue_drained", q.size(), 32'd0);
        mon_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
